// File: rtl/neopixel_pkg.sv
// Shared types and timing helpers for the WS2812 chain controller.
// All pulse widths are derived from the system clock frequency.
package neopixel_pkg;

    localparam int COLOR_W = 24;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        LATCH
    } state_e;

    function automatic int t_short(input int hz);
        return hz / 3_333_333;
    endfunction

    function automatic int t_long(input int hz);
        return hz / 1_111_111;
    endfunction

    function automatic int t_latch(input int hz);
        return hz / 12_500;
    endfunction

endpackage

// File: rtl/neopixel_bit_serializer.sv
// Shifts one 24-bit GRB word onto the one-wire line, MSB first.
// A single counter spans the whole bit period; the high phase is a compare.
module neopixel_bit_serializer
    import neopixel_pkg::*;
#(
    parameter int CLOCK_SPEED_HZ = 32_000_000
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [COLOR_W-1:0] data,
    output logic               one_wire,
    output logic               done
);

    localparam int TS = t_short(CLOCK_SPEED_HZ);
    localparam int TL = t_long(CLOCK_SPEED_HZ);
    localparam int TP = TS + TL;
    localparam int CW = $clog2(TP);
    localparam int BW = $clog2(COLOR_W);

    logic [COLOR_W-1:0] shift_q, shift_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic               active_q, active_d;
    logic               end_of_bit;

    assign end_of_bit = active_q && (cnt_q == CW'(TP - 1));
    assign one_wire   = active_q &&
        (cnt_q < (shift_q[COLOR_W-1] ? CW'(TL) : CW'(TS)));

    // done marks the final low clock of the last bit so LOAD follows back-to-back
    always_comb begin
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        active_d = active_q;
        done     = 1'b0;
        if (start) begin
            shift_d  = data;
            cnt_d    = '0;
            bit_d    = '0;
            active_d = 1'b1;
        end else if (end_of_bit) begin
            cnt_d   = '0;
            shift_d = {shift_q[COLOR_W-2:0], 1'b0};
            if (bit_q == BW'(COLOR_W - 1)) begin
                active_d = 1'b0;
                done     = 1'b1;
            end else begin
                bit_d = bit_q + BW'(1);
            end
        end else if (active_q) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_q  <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
            active_q <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/neopixel_chain_ctrl.sv
// Frame sequencer for a WS2812 string: pixel bank, frame FSM,
// latch gap, optional auto-refresh and request coalescing.
module neopixel_chain_ctrl
    import neopixel_pkg::*;
#(
    parameter  int CLOCK_SPEED_HZ = 32_000_000,
    parameter  int NUM_PIXELS     = 8,
    parameter  int REFRESH_CYCLES = 0,
    localparam int AW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [COLOR_W-1:0] wr_color,
    input  logic               refresh,
    output logic               busy,
    output logic               frame_done,
    output logic               one_wire
);

    localparam int TLAT = t_latch(CLOCK_SPEED_HZ);
    localparam int LW   = (TLAT > 1) ? $clog2(TLAT) : 1;

    state_e             state_q, state_d;
    logic [AW-1:0]      pix_q, pix_d;
    logic [LW-1:0]      latch_q, latch_d;
    logic               pending_q, pending_d;
    logic               frame_done_q, frame_done_d;
    logic [COLOR_W-1:0] bank_q [NUM_PIXELS];

    logic ser_wire;
    logic ser_done;
    logic auto_req;
    logic req;

    if (REFRESH_CYCLES > 0) begin : g_auto
        localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
        logic [RW-1:0] rcnt_q;
        assign auto_req = (rcnt_q == RW'(REFRESH_CYCLES - 1));
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) rcnt_q <= '0;
            else          rcnt_q <= auto_req ? '0 : rcnt_q + RW'(1);
        end
    end else begin : g_no_auto
        assign auto_req = 1'b0;
    end

    assign req = refresh | auto_req;

    // Writes land at end of cycle, so a LOAD in the same cycle sees the old word
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PIXELS; i++) bank_q[i] <= '0;
        end else if (wr_en && (int'(wr_addr) < NUM_PIXELS)) begin
            bank_q[wr_addr] <= wr_color;
        end
    end

    always_comb begin
        state_d      = state_q;
        pix_d        = pix_q;
        latch_d      = latch_q;
        pending_d    = pending_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req || pending_q) begin
                    pix_d     = '0;
                    pending_d = 1'b0;
                    state_d   = LOAD;
                end
            end
            LOAD: state_d = SEND;
            SEND: begin
                if (ser_done) begin
                    if (pix_q == AW'(NUM_PIXELS - 1)) begin
                        latch_d = '0;
                        state_d = LATCH;
                    end else begin
                        pix_d   = pix_q + AW'(1);
                        state_d = LOAD;
                    end
                end
            end
            LATCH: begin
                if (latch_q == LW'(TLAT - 1)) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    latch_d = latch_q + LW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && req) pending_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pix_q        <= '0;
            latch_q      <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_q        <= pix_d;
            latch_q      <= latch_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
        end
    end

    neopixel_bit_serializer #(
        .CLOCK_SPEED_HZ(CLOCK_SPEED_HZ)
    ) u_ser (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (state_q == LOAD),
        .data    (bank_q[pix_q]),
        .one_wire(ser_wire),
        .done    (ser_done)
    );

    assign one_wire   = ser_wire & (state_q == SEND);
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_neopixel_chain_ctrl.sv
// Scoreboard bench: dut A (3 pixels, manual refresh), dut B (1 pixel, auto-refresh).
module tb_neopixel_chain_ctrl;

    localparam int TS = 9;
    localparam int TL = 28;
    localparam int TP = 37;
    localparam int FA = 5228;
    localparam int FB = 3450;

    logic        clk;
    logic [1:0]  rstn, wen, refr, bsy, fd, ow;
    logic [1:0]  waddr_a;
    logic [0:0]  waddr_b;
    logic [23:0] wcol_a, wcol_b;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;
    int tb0, t;

    logic [23:0] exp_pix  [2][$];
    int          exp_rise [2][$];
    int          exp_done [2][$];

    int          hi [2], lo [2], nb [2], exlo [2], ndone [2];
    logic        prev [2], infr [2];
    logic [23:0] sh [2];

    neopixel_chain_ctrl #(
        .CLOCK_SPEED_HZ(32_000_000), .NUM_PIXELS(3), .REFRESH_CYCLES(0)
    ) u_a (
        .clock(clk), .reset_n(rstn[0]), .wr_en(wen[0]), .wr_addr(waddr_a),
        .wr_color(wcol_a), .refresh(refr[0]), .busy(bsy[0]),
        .frame_done(fd[0]), .one_wire(ow[0])
    );

    neopixel_chain_ctrl #(
        .CLOCK_SPEED_HZ(32_000_000), .NUM_PIXELS(1), .REFRESH_CYCLES(10000)
    ) u_b (
        .clock(clk), .reset_n(rstn[1]), .wr_en(wen[1]), .wr_addr(waddr_b),
        .wr_color(wcol_b), .refresh(refr[1]), .busy(bsy[1]),
        .frame_done(fd[1]), .one_wire(ow[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog ncyc=%0d", ncyc);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, ncyc, act, exp);
        end
    endtask

    task automatic chk_avail(input string nm, input int g, input int sz);
        checks++;
        if (sz == 0) begin
            errors++;
            $display("FAIL %s dut=%0d cyc=%0d got=unexpected want=none", nm, g, ncyc);
        end
    endtask

    task automatic mon(input int g);
        logic b;
        if (!rstn[g]) begin
            prev[g] = 1'b0;
            infr[g] = 1'b0;
            nb[g]   = 0;
            return;
        end
        if (ow[g]) begin
            if (!prev[g]) begin
                if (infr[g]) begin
                    chk($sformatf("low_len%0d", g), lo[g], exlo[g]);
                end else begin
                    chk_avail("rise_q", g, exp_rise[g].size());
                    if (exp_rise[g].size() > 0)
                        chk($sformatf("start_cyc%0d", g), ncyc, exp_rise[g].pop_front());
                    infr[g] = 1'b1;
                end
                hi[g] = 1;
            end else begin
                hi[g]++;
            end
        end else begin
            if (prev[g]) begin
                b = (hi[g] == TL);
                checks++;
                if (hi[g] != TL && hi[g] != TS) begin
                    errors++;
                    $display("FAIL high_len%0d cyc=%0d got=%0d want=%0d|%0d",
                             g, ncyc, hi[g], TS, TL);
                end
                sh[g]   = {sh[g][22:0], b};
                nb[g]++;
                exlo[g] = TP - hi[g];
                if (nb[g] == 24) begin
                    chk_avail("pix_q", g, exp_pix[g].size());
                    if (exp_pix[g].size() > 0)
                        chk($sformatf("pixel%0d", g), sh[g], exp_pix[g].pop_front());
                    nb[g]   = 0;
                    exlo[g] = exlo[g] + 1;
                end
                lo[g] = 1;
            end else begin
                lo[g]++;
            end
        end
        prev[g] = ow[g];
        if (fd[g]) begin
            chk_avail("done_q", g, exp_done[g].size());
            if (exp_done[g].size() > 0)
                chk($sformatf("done_cyc%0d", g), ncyc, exp_done[g].pop_front());
            chk($sformatf("done_bits%0d", g), nb[g], 0);
            infr[g] = 1'b0;
            ndone[g]++;
        end
    endtask

    always @(negedge clk) begin
        ncyc++;
        mon(0);
        mon(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (ncyc + 1 < c) tick();
    endtask

    task automatic wr_a(input logic [1:0] a, input logic [23:0] c);
        wen[0] = 1'b1; waddr_a = a; wcol_a = c;
        tick();
        wen[0] = 1'b0;
    endtask

    task automatic pulse_a(output int t0);
        t0 = ncyc + 1;
        refr[0] = 1'b1;
        tick();
        refr[0] = 1'b0;
    endtask

    task automatic push_a(input int t0, input logic [23:0] p0, p1, p2);
        exp_rise[0].push_back(t0 + 2);
        exp_done[0].push_back(t0 + FA);
        exp_pix[0].push_back(p0);
        exp_pix[0].push_back(p1);
        exp_pix[0].push_back(p2);
    endtask

    task automatic frame_a(input logic [23:0] p0, p1, p2, output int t0);
        push_a(ncyc + 1, p0, p1, p2);
        pulse_a(t0);
    endtask

    initial begin
        int dummy;
        for (int g = 0; g < 2; g++) begin
            hi[g] = 0; lo[g] = 0; nb[g] = 0; exlo[g] = 0; ndone[g] = 0;
            prev[g] = 1'b0; infr[g] = 1'b0; sh[g] = '0;
        end
        rstn = 2'b00; wen = 2'b00; refr = 2'b00;
        waddr_a = '0; waddr_b = '0; wcol_a = '0; wcol_b = '0;
        repeat (3) tick();
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("rst_busy%0d", g), bsy[g], 0);
            chk($sformatf("rst_wire%0d", g), ow[g], 0);
            chk($sformatf("rst_done%0d", g), fd[g], 0);
        end
        rstn = 2'b11;
        tb0  = ncyc + 1;

        // dut B: single pixel FF0000, manual frame then auto frames
        wen[1] = 1'b1; waddr_b = 1'b0; wcol_b = 24'hFF0000;
        tick();
        wen[1] = 1'b0;
        t = ncyc + 1;
        exp_rise[1].push_back(t + 2);
        exp_done[1].push_back(t + FB);
        exp_pix[1].push_back(24'hFF0000);
        refr[1] = 1'b1;
        tick();
        refr[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_rise[1].push_back(tb0 + 9999 + 2 + k * 10000);
            exp_done[1].push_back(tb0 + 9999 + FB + k * 10000);
            exp_pix[1].push_back(24'hFF0000);
        end

        // dut A: three-pixel frame
        wr_a(2'd0, 24'h000001);
        wr_a(2'd1, 24'h800000);
        wr_a(2'd2, 24'hAAAAAA);
        frame_a(24'h000001, 24'h800000, 24'hAAAAAA, t);
        goto(t + FA + 1);
        chk("busy_after_frame", bsy[0], 0);

        // requests during a frame coalesce; request on frame_done adds one
        frame_a(24'h000001, 24'h800000, 24'hAAAAAA, t);
        goto(t + 100);  pulse_a(dummy);
        goto(t + 2000); pulse_a(dummy);
        goto(t + FA - 1); pulse_a(dummy);
        push_a(t + FA, 24'h000001, 24'h800000, 24'hAAAAAA);
        goto(t + 2 * FA);
        push_a(t + 2 * FA, 24'h000001, 24'h800000, 24'hAAAAAA);
        pulse_a(dummy);
        goto(t + 3 * FA + 50);
        chk("busy_after_coalesce", bsy[0], 0);

        // writes during a frame: later pixel updated, same-cycle LOAD keeps old
        frame_a(24'h000001, 24'h800000, 24'h00FF00, t);
        goto(t + 100);
        wr_a(2'd2, 24'h00FF00);
        wr_a(2'd3, 24'hDEADBE);
        goto(t + 890);
        wr_a(2'd1, 24'h123456);
        goto(t + FA + 60);
        frame_a(24'h000001, 24'h123456, 24'h00FF00, t);
        goto(t + FA + 60);

        // reset mid-bit
        frame_a(24'h000001, 24'h123456, 24'h00FF00, t);
        goto(t + 5);
        chk("mid_bit_high", ow[0], 1);
        rstn[0] = 1'b0;
        #1;
        chk("rst_mid_wire", ow[0], 0);
        chk("rst_mid_busy", bsy[0], 0);
        exp_pix[0].delete();
        exp_done[0].delete();
        tick();
        tick();
        rstn[0] = 1'b1;
        tick();
        frame_a(24'h000000, 24'h000000, 24'h000000, t);
        goto(t + FA + 60);

        goto(tb0 + 9999 + FB + 30000 + 100);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("left_pix%0d", g), exp_pix[g].size(), 0);
            chk($sformatf("left_rise%0d", g), exp_rise[g].size(), 0);
            chk($sformatf("left_done%0d", g), exp_done[g].size(), 0);
        end
        chk("frames_a", ndone[0], 7);
        chk("frames_b", ndone[1], 5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
